// File: rtl/branch_pkg.sv
// Shared types for branch resolution: branch kinds, ARM condition codes,
// controller states and NZCV bit positions.
package branch_pkg;

    typedef enum logic [1:0] {
        BR_NONE   = 2'd0,
        BR_UNCOND = 2'd1,
        BR_COND   = 2'd2,
        BR_CBZ    = 2'd3
    } br_type_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/branch_flag_ctrl_if.sv
// Pipeline-side signals of the branch/flag controller; master drives the
// EX/ID inputs, slave is the controller.
interface branch_flag_ctrl_if;
    logic       ex_valid;
    logic       ex_setflags;
    logic [3:0] ex_flags;
    logic       ex_flag_busy;
    logic       id_br_valid;
    logic [1:0] id_br_type;
    logic [3:0] id_cond;
    logic       id_rt_zero;
    logic [3:0] flags_q;
    logic       br_taken;
    logic       stall_id;
    logic       flush;

    modport master (
        output ex_valid, ex_setflags, ex_flags, ex_flag_busy,
               id_br_valid, id_br_type, id_cond, id_rt_zero,
        input  flags_q, br_taken, stall_id, flush
    );

    modport slave (
        input  ex_valid, ex_setflags, ex_flags, ex_flag_busy,
               id_br_valid, id_br_type, id_cond, id_rt_zero,
        output flags_q, br_taken, stall_id, flush
    );
endinterface

// File: rtl/branch_flag_ctrl_cond_eval.sv
// Combinational ARM condition-code evaluator: (cond, NZCV) -> pass.
// Kept standalone so a conditional-select unit can reuse it.
module cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       taken
);
    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        taken = 1'b0;
        case (cond_t'(cond))
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_HS: taken = c;
            COND_LO: taken = ~c;
            COND_MI: taken = n;
            COND_PL: taken = ~n;
            COND_VS: taken = v;
            COND_VC: taken = ~v;
            COND_HI: taken = c & ~z;
            COND_LS: taken = ~c | z;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = ~z & (n == v);
            COND_LE: taken = z | (n != v);
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_flag_ctrl.sv
// NZCV flag register plus branch resolution: forwards EX flags, stalls ID
// behind a multi-cycle flag producer, and emits taken/flush pulses.
module branch_flag_ctrl
    import branch_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 3
) (
    input  logic               clk,
    input  logic               reset,
    branch_flag_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       flags_r;
    logic             br_taken_r;
    logic             flush_r;

    logic       fwd, busy_hold, wait_enter, cond_pass, decision, stall;
    logic [3:0] eff_flags;

    // A flag-setting EX op that has finished overrides the stored flags this cycle.
    assign fwd       = bus.ex_valid & bus.ex_setflags & ~bus.ex_flag_busy;
    assign busy_hold = bus.ex_valid & bus.ex_setflags & bus.ex_flag_busy;
    assign eff_flags = fwd ? bus.ex_flags : flags_r;

    assign wait_enter = (state == IDLE) & bus.id_br_valid &
                        (br_type_t'(bus.id_br_type) == BR_COND) & busy_hold;

    cond_eval u_cond_eval (
        .cond  (bus.id_cond),
        .nzcv  (eff_flags),
        .taken (cond_pass)
    );

    always_comb begin
        decision = 1'b0;
        if (bus.id_br_valid) begin
            case (br_type_t'(bus.id_br_type))
                BR_UNCOND: decision = 1'b1;
                BR_COND:   decision = cond_pass;
                BR_CBZ:    decision = bus.id_rt_zero;
                default:   decision = 1'b0;
            endcase
        end
    end

    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    stall = wait_enter;
                WAIT:    stall = bus.ex_flag_busy;
                default: stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            flags_r    <= '0;
            br_taken_r <= 1'b0;
            flush_r    <= 1'b0;
        end else begin
            br_taken_r <= 1'b0;
            if (fwd && !flush_r)
                flags_r <= bus.ex_flags;
            case (state)
                IDLE, WAIT: begin
                    if (stall) begin
                        state <= WAIT;
                    end else if (decision) begin
                        state      <= FLUSH;
                        br_taken_r <= 1'b1;
                        flush_r    <= 1'b1;
                        cnt        <= CNT_INIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                // The instruction in ID is being squashed, so its branch is ignored.
                FLUSH: begin
                    if (cnt == '0) begin
                        flush_r <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    flush_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.flags_q  = flags_r;
    assign bus.br_taken = br_taken_r;
    assign bus.flush    = flush_r;
    assign bus.stall_id = stall;
endmodule

// File: tb/tb_branch_flag_ctrl.sv
// Bench for branch_flag_ctrl: two instances (1- and 3-cycle flush) fed the
// same stimulus; condition table, directed corner cases, random vs model.
module tb_branch_flag_ctrl;
    import branch_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    branch_flag_ctrl_if bif1 ();
    branch_flag_ctrl_if bif3 ();

    assign bif3.ex_valid     = bif1.ex_valid;
    assign bif3.ex_setflags  = bif1.ex_setflags;
    assign bif3.ex_flags     = bif1.ex_flags;
    assign bif3.ex_flag_busy = bif1.ex_flag_busy;
    assign bif3.id_br_valid  = bif1.id_br_valid;
    assign bif3.id_br_type   = bif1.id_br_type;
    assign bif3.id_cond      = bif1.id_cond;
    assign bif3.id_rt_zero   = bif1.id_rt_zero;

    branch_flag_ctrl #(.FLUSH_CYCLES(1), .CNT_W(3)) dut1 (.clk(clk), .reset(reset), .bus(bif1));
    branch_flag_ctrl #(.FLUSH_CYCLES(3), .CNT_W(3)) dut3 (.clk(clk), .reset(reset), .bus(bif3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] fl;
        logic [1:0] bt;
        logic [3:0] cd;
        logic       exp;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit ev, input bit sf, input logic [3:0] fl, input bit busy,
                          input bit bv, input logic [1:0] bt, input logic [3:0] cd, input bit rz);
        bif1.ex_valid     = ev;
        bif1.ex_setflags  = sf;
        bif1.ex_flags     = fl;
        bif1.ex_flag_busy = busy;
        bif1.id_br_valid  = bv;
        bif1.id_br_type   = bt;
        bif1.id_cond      = cd;
        bif1.id_rt_zero   = rz;
    endtask

    task automatic idle_in();
        set_in(0, 0, 4'h0, 0, 0, 2'd0, 4'h0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Condition semantics as ARM defines them: base test from cond[3:1],
    // odd codes invert it except for the always group.
    function automatic bit mcond(input logic [3:0] cd, input logic [3:0] f);
        bit n, z, c, v, r;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cd[3:1])
            3'd0: r = z;
            3'd1: r = c;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = c && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (cd[0] && cd[3:1] != 3'd7) r = !r;
        return r;
    endfunction

    bit [3:0] m_flags[2];
    int       m_left[2];
    bit       m_wait[2];
    bit       m_pulse[2];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        vecs[0]  = '{4'b0100, 2'd2, 4'h0, 1'b1};
        vecs[1]  = '{4'b0100, 2'd2, 4'h1, 1'b0};
        vecs[2]  = '{4'b0010, 2'd2, 4'h2, 1'b1};
        vecs[3]  = '{4'b0000, 2'd2, 4'h3, 1'b1};
        vecs[4]  = '{4'b1000, 2'd2, 4'h4, 1'b1};
        vecs[5]  = '{4'b1000, 2'd2, 4'h5, 1'b0};
        vecs[6]  = '{4'b0001, 2'd2, 4'h6, 1'b1};
        vecs[7]  = '{4'b0001, 2'd2, 4'h7, 1'b0};
        vecs[8]  = '{4'b0010, 2'd2, 4'h8, 1'b1};
        vecs[9]  = '{4'b0110, 2'd2, 4'h8, 1'b0};
        vecs[10] = '{4'b0110, 2'd2, 4'h9, 1'b1};
        vecs[11] = '{4'b1001, 2'd2, 4'hA, 1'b1};
        vecs[12] = '{4'b1000, 2'd2, 4'hB, 1'b1};
        vecs[13] = '{4'b0000, 2'd2, 4'hC, 1'b1};
        vecs[14] = '{4'b0100, 2'd2, 4'hC, 1'b0};
        vecs[15] = '{4'b1000, 2'd2, 4'hD, 1'b1};
        vecs[16] = '{4'b0000, 2'd2, 4'hE, 1'b1};
        vecs[17] = '{4'b0000, 2'd2, 4'hF, 1'b1};
        vecs[18] = '{4'b0100, 2'd0, 4'h0, 1'b0};
        vecs[19] = '{4'b0100, 2'd1, 4'h1, 1'b1};

        // Reset: stall must stay low even with a stall-worthy request present.
        reset = 1'b1;
        idle_in();
        tick(); tick();
        set_in(1, 1, 4'h0, 1, 1, 2'd2, 4'h0, 0);
        #1;
        chk("stall_in_reset", {3'b0, bif1.stall_id}, 4'h0);
        idle_in();
        reset = 1'b0;
        tick();
        chk("rst_flags1", bif1.flags_q, 4'h0);
        chk("rst_taken1", {3'b0, bif1.br_taken}, 4'h0);
        chk("rst_flush1", {3'b0, bif1.flush}, 4'h0);
        chk("rst_flush3", {3'b0, bif3.flush}, 4'h0);

        // Condition table: SUBS writes flags, B.cond follows the next cycle.
        for (int i = 0; i < 20; i++) begin
            set_in(1, 1, vecs[i].fl, 0, 0, 2'd0, 4'h0, 0);
            tick();
            chk($sformatf("tbl%0d_flags", i), bif1.flags_q, vecs[i].fl);
            set_in(0, 0, 4'h0, 0, 1, vecs[i].bt, vecs[i].cd, 0);
            #1;
            chk($sformatf("tbl%0d_stall", i), {3'b0, bif1.stall_id}, 4'h0);
            tick();
            chk($sformatf("tbl%0d_taken1", i), {3'b0, bif1.br_taken}, {3'b0, vecs[i].exp});
            chk($sformatf("tbl%0d_flush1", i), {3'b0, bif1.flush}, {3'b0, vecs[i].exp});
            chk($sformatf("tbl%0d_taken3", i), {3'b0, bif3.br_taken}, {3'b0, vecs[i].exp});
            idle_in();
            tick(); tick(); tick();
        end

        // Same-cycle forward of fresh flags into the branch decision.
        set_in(1, 1, 4'b0000, 0, 0, 2'd0, 4'h0, 0);
        tick();
        set_in(1, 1, 4'b1000, 0, 1, 2'd2, 4'h4, 0);
        tick();
        chk("fwd_taken", {3'b0, bif1.br_taken}, 4'h1);
        chk("fwd_flush", {3'b0, bif1.flush}, 4'h1);
        chk("fwd_flags", bif1.flags_q, 4'b1000);
        idle_in();
        tick(); tick(); tick();

        // Busy producer holds B.cond GE for three cycles.
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 4'b0000, 1, 1, 2'd2, 4'hA, 0);
            #1;
            chk($sformatf("busy_stall%0d", i), {3'b0, bif1.stall_id}, 4'h1);
            chk($sformatf("busy_stall3_%0d", i), {3'b0, bif3.stall_id}, 4'h1);
            tick();
            chk($sformatf("busy_notaken%0d", i), {3'b0, bif1.br_taken}, 4'h0);
        end
        set_in(1, 1, 4'b1001, 0, 1, 2'd2, 4'hA, 0);
        #1;
        chk("busy_release_stall", {3'b0, bif1.stall_id}, 4'h0);
        tick();
        chk("busy_taken", {3'b0, bif1.br_taken}, 4'h1);
        chk("busy_flags", bif1.flags_q, 4'b1001);
        idle_in();
        tick(); tick(); tick();

        // CBZ ignores flag-producer busy and follows the zero detect.
        set_in(1, 1, 4'b0000, 1, 1, 2'd3, 4'h1, 1);
        #1;
        chk("cbz_nostall", {3'b0, bif1.stall_id}, 4'h0);
        tick();
        chk("cbz_taken", {3'b0, bif1.br_taken}, 4'h1);
        idle_in();
        tick(); tick(); tick();
        set_in(1, 1, 4'b0000, 1, 1, 2'd3, 4'h0, 0);
        #1;
        chk("cbz0_nostall", {3'b0, bif1.stall_id}, 4'h0);
        tick();
        chk("cbz0_taken", {3'b0, bif1.br_taken}, 4'h0);
        chk("cbz0_flush", {3'b0, bif1.flush}, 4'h0);
        idle_in();
        tick();

        // Three-cycle flush: branches and SUBS during flush are ignored.
        set_in(0, 0, 4'h0, 0, 1, 2'd1, 4'h0, 0);
        tick();
        chk("f3_taken", {3'b0, bif3.br_taken}, 4'h1);
        chk("f3_flush_c1", {3'b0, bif3.flush}, 4'h1);
        set_in(1, 1, 4'b0110, 0, 1, 2'd1, 4'h0, 0);
        tick();
        chk("f3_taken_c2", {3'b0, bif3.br_taken}, 4'h0);
        chk("f3_flush_c2", {3'b0, bif3.flush}, 4'h1);
        chk("f3_flags_c2", bif3.flags_q, 4'b1001);
        tick();
        chk("f3_flush_c3", {3'b0, bif3.flush}, 4'h1);
        chk("f3_flags_c3", bif3.flags_q, 4'b1001);
        idle_in();
        tick();
        chk("f3_flush_end", {3'b0, bif3.flush}, 4'h0);
        chk("f3_taken_end", {3'b0, bif3.br_taken}, 4'h0);
        set_in(0, 0, 4'h0, 0, 1, 2'd1, 4'h0, 0);
        tick();
        chk("f3_post_taken", {3'b0, bif3.br_taken}, 4'h1);
        idle_in();

        // Asynchronous reset in the middle of a flush.
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_flush3", {3'b0, bif3.flush}, 4'h0);
        chk("midrst_taken3", {3'b0, bif3.br_taken}, 4'h0);
        chk("midrst_flags3", bif3.flags_q, 4'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("midrst_after_flush", {3'b0, bif3.flush}, 4'h0);
        set_in(0, 0, 4'h0, 0, 1, 2'd1, 4'h0, 0);
        tick();
        chk("midrst_idle_taken", {3'b0, bif3.br_taken}, 4'h1);
        idle_in();

        // Random phase from a clean reset against the behavioural model.
        reset = 1'b1;
        #3;
        reset = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            m_flags[k] = 4'h0; m_left[k] = 0; m_wait[k] = 1'b0; m_pulse[k] = 1'b0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit st[2];
            if (m_wait[0] || m_wait[1]) begin
                bif1.ex_flags     = 4'($urandom);
                bif1.ex_flag_busy = ($urandom_range(0, 2) == 0);
            end else begin
                set_in($urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom),
                       $urandom_range(0, 2) == 0, $urandom_range(0, 1),
                       2'($urandom), 4'($urandom), $urandom_range(0, 1));
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                bit busy_op, fwd_op, dec;
                bit [3:0] eff;
                busy_op = bif1.ex_valid && bif1.ex_setflags && bif1.ex_flag_busy;
                fwd_op  = bif1.ex_valid && bif1.ex_setflags && !bif1.ex_flag_busy;
                st[k] = 1'b0;
                if (m_left[k] == 0)
                    st[k] = m_wait[k] ? bif1.ex_flag_busy
                                      : (bif1.id_br_valid && bif1.id_br_type == 2'd2 && busy_op);
                eff = fwd_op ? bif1.ex_flags : m_flags[k];
                m_pulse[k] = 1'b0;
                if (m_left[k] > 0) begin
                    m_left[k]--;
                end else begin
                    dec = bif1.id_br_valid &&
                          (bif1.id_br_type == 2'd1 ||
                           (bif1.id_br_type == 2'd2 && mcond(bif1.id_cond, eff)) ||
                           (bif1.id_br_type == 2'd3 && bif1.id_rt_zero));
                    if (fwd_op) m_flags[k] = bif1.ex_flags;
                    m_wait[k] = st[k];
                    if (!st[k] && dec) begin
                        m_left[k]  = (k == 0) ? 1 : 3;
                        m_pulse[k] = 1'b1;
                    end
                end
            end
            chk("rnd_stall1", {3'b0, bif1.stall_id}, {3'b0, st[0]});
            chk("rnd_stall3", {3'b0, bif3.stall_id}, {3'b0, st[1]});
            tick();
            chk("rnd_flags1", bif1.flags_q, m_flags[0]);
            chk("rnd_taken1", {3'b0, bif1.br_taken}, {3'b0, m_pulse[0]});
            chk("rnd_flush1", {3'b0, bif1.flush}, {3'b0, m_left[0] > 0});
            chk("rnd_flags3", bif3.flags_q, m_flags[1]);
            chk("rnd_taken3", {3'b0, bif3.br_taken}, {3'b0, m_pulse[1]});
            chk("rnd_flush3", {3'b0, bif3.flush}, {3'b0, m_left[1] > 0});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/branch_flag_ctrl.md
Name: branch_flag_ctrl

Overview:
- Owns the architectural NZCV flag register and resolves conditional branches (B, B.cond, CBZ) in the pipelined CPU.
- Takes flags from the EX-stage ALU, with Z coming from the zero-detect tree.
- For CBZ it takes a zero indication from a second zero-detect instance on the ID-stage register operand.
- Sequences ID stalls while a multi-cycle flag producer is busy, and flush pulses after a taken branch.

Parameters:
FLUSH_CYCLES, 1, cycles flush held high after a taken decision (1..7)
CNT_W, 3, width of flush down-counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
ex_valid  input  1  EX-stage instruction valid
ex_setflags  input  1  EX instruction writes NZCV (ADDS/SUBS)
ex_flags  input  4  {N,Z,C,V} from ALU; Z = zero-detect output
ex_flag_busy  input  1  multi-cycle flag producer in EX not finished
id_br_valid  input  1  ID holds a branch
id_br_type  input  2  0 none, 1 B (uncond), 2 B.cond, 3 CBZ
id_cond  input  4  ARM condition code for B.cond
id_rt_zero  input  1  zero-detect of CBZ operand
flags_q  output  4  architectural {N,Z,C,V}
br_taken  output  1  registered one-cycle pulse: branch taken
stall_id  output  1  combinational: hold ID/IF this cycle
flush  output  1  registered: squash IF/ID

Behaviour:
- Reset (async, immediate):
  - flags_q=0, br_taken=0, flush=0, counter=0, state=IDLE.
  - stall_id=0 while reset is high.
  - Reset mid-FLUSH or mid-WAIT abandons the pending branch.
- Flag write: at posedge, flags_q<=ex_flags when ex_valid && ex_setflags && !ex_flag_busy && !flush.
- Effective flags for evaluation:
  - ex_flags when ex_valid && ex_setflags && !ex_flag_busy (same-cycle forward).
  - Otherwise flags_q.
- Condition eval:
  - EQ Z; NE !Z; HS C; LO !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL and NV both true.
- Decision by type:
  - B always taken.
  - B.cond taken per eval.
  - CBZ taken = id_rt_zero; CBZ ignores flags and never stalls.
  - type 0 never taken.
- FSM IDLE:
  - If id_br_valid, type=2, ex_valid && ex_setflags && ex_flag_busy: stall_id=1, go WAIT.
  - Else if id_br_valid and taken: br_taken=1 next cycle, flush=1 next cycle, counter<=FLUSH_CYCLES-1, go FLUSH.
  - Else stay; not-taken produces no outputs.
- FSM WAIT:
  - stall_id=1 while ex_flag_busy=1.
  - In the cycle busy drops, stall_id=0; the branch (held stable by upstream) is evaluated with forwarded ex_flags, then proceed as in IDLE.
- FSM FLUSH:
  - flush=1 for exactly FLUSH_CYCLES cycles; br_taken only in the first.
  - id_br_valid is ignored (squashed instruction).
  - Counter decrements to 0, then go IDLE.
  - A branch in ID in the first post-FLUSH cycle is evaluated normally.
- Latency: decision to br_taken/flush is 1 cycle; stall_id is same-cycle.
- Simultaneous events:
  - Flag write and branch eval in the same cycle: branch uses the new (forwarded) flags.
  - Flag write suppressed while flush=1.

Decomposition:
- Package branch_pkg holds:
  - br_type_t enum (BR_NONE, BR_UNCOND, BR_COND, BR_CBZ);
  - cond_t constants 4'h0..4'hF;
  - state_t (IDLE, WAIT, FLUSH);
  - flag bit index constants N=3, Z=2, C=1, V=0.
- One natural sub-module, cond_eval: purely combinational, (cond, nzcv) -> taken. It is reusable by a later conditional-select unit.

Test Plan:
- Reset then idle: flags_q=0, br_taken=0, flush=0; assert reset mid-FLUSH -> all outputs 0 immediately, state IDLE.
- SUBS writing ex_flags=4'b0100 (Z), next cycle B.cond EQ (cond 0) -> br_taken=1, flush=1 one cycle later; NE (cond 1) with the same flags -> no pulse.
- Same-cycle forward: flags_q=0, EX SUBS ex_flags=4'b1000 concurrent with B.cond MI (cond 4) -> taken, flags_q=4'b1000 after edge.
- Busy producer: ex_flag_busy=1 for 3 cycles with B.cond GE pending -> stall_id=1 for those 3 cycles, stall_id=0 on the 4th; N=1,V=1 -> taken.
- CBZ: id_rt_zero=1 -> taken, no stall even with ex_flag_busy=1; id_rt_zero=0 -> not taken.
- FLUSH_CYCLES=3: taken B -> flush high exactly 3 cycles, br_taken 1 cycle, branch presented during flush ignored, SUBS during flush leaves flags_q unchanged.
